// File: rtl/xilinx_phy10g_pkg.sv
// Shared DRP widths, arbiter FSM encoding and index-width helper.
// Imported by the DRP arbiter and its round-robin picker.
package xilinx_phy10g_pkg;

  localparam int DRP_ADDR_W = 9;
  localparam int DRP_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } drp_arb_state_t;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xilinx_phy10g_drp_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request after last_grant, wrapping; zero latency.
// No state and no backpressure; any_o is low when the request vector is empty.
module rr_arbiter
  import xilinx_phy10g_pkg::*;
#(
  parameter int N_REQ = 8,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] w_pos;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    w_pos   = '0;
    // Scan last_grant+1 upward; the last position checked is last_grant itself.
    for (int k = 1; k <= N_REQ; k++) begin
      w_pos = IDX_W'((int'(last_grant_i) + k) % N_REQ);
      if (!any_o && req_i[w_pos]) begin
        grant_o[w_pos] = 1'b1;
        idx_o          = w_pos;
        any_o          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xilinx_phy10g_drp_arbiter.sv
// Round-robin DRP port sharer: accept T, drp_en T+1, response one cycle after drp_rdy (or timeout).
// One transaction in flight; requesters hold valid until accepted. DRP_ARB_LOCK_EN adds req_lock_i for atomic RMW.
module xilinx_phy10g_drp_arbiter
  import xilinx_phy10g_pkg::*;
#(
  parameter int N_REQ          = 8,
  parameter int ADDR_W         = DRP_ADDR_W,
  parameter int DATA_W         = DRP_DATA_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  output logic [N_REQ-1:0]         req_ready_o,
  input  logic [N_REQ-1:0]         req_we_i,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr_i,
  input  logic [N_REQ*DATA_W-1:0]  req_data_i,
`ifdef DRP_ARB_LOCK_EN
  input  logic [N_REQ-1:0]         req_lock_i,
`endif
  output logic [N_REQ-1:0]         rsp_valid_o,
  output logic [DATA_W-1:0]        rsp_data_o,
  output logic                     rsp_timeout_o,
  output logic                     drp_en_o,
  output logic                     drp_we_o,
  output logic [ADDR_W-1:0]        drp_addr_o,
  output logic [DATA_W-1:0]        drp_di_o,
  input  logic [DATA_W-1:0]        drp_do_i,
  input  logic                     drp_rdy_i
);

  localparam int IDX_W = idx_width(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  drp_arb_state_t    r_state;
  drp_arb_state_t    w_next;
  logic [IDX_W-1:0]  r_last;
  logic [IDX_W-1:0]  r_idx;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_di;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_to;

  logic [N_REQ-1:0]  w_elig;
  logic [N_REQ-1:0]  w_grant;
  logic [IDX_W-1:0]  w_idx;
  logic              w_any;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_timeout;

  assign w_timeout = (r_cnt == CNT_LAST);

`ifdef DRP_ARB_LOCK_EN
  logic             r_locked;
  logic [IDX_W-1:0] r_lock_idx;

  // While locked, only the lock owner may be granted.
  assign w_elig = r_locked ? (req_valid_i & (N_REQ'(1) << r_lock_idx)) : req_valid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_locked   <= 1'b0;
      r_lock_idx <= '0;
    end else if (r_state == RESP && req_lock_i[r_idx]) begin
      r_locked   <= 1'b1;
      r_lock_idx <= r_idx;
    end else if (r_state == IDLE && r_locked && !req_lock_i[r_lock_idx]) begin
      r_locked   <= 1'b0;
    end
  end
`else
  assign w_elig = req_valid_i;
`endif

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i        (w_elig),
    .last_grant_i (r_last),
    .grant_o      (w_grant),
    .idx_o        (w_idx),
    .any_o        (w_any)
  );

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_idx == IDX_W'(i)) begin
        w_sel_addr = req_addr_i[i*ADDR_W +: ADDR_W];
        w_sel_data = req_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (drp_rdy_i || w_timeout) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o   = '0;
    rsp_valid_o   = '0;
    rsp_data_o    = '0;
    rsp_timeout_o = 1'b0;
    drp_en_o      = 1'b0;
    if (!rst_i) begin
      case (r_state)
        IDLE:  req_ready_o = w_grant;
        ISSUE: drp_en_o = 1'b1;
        RESP: begin
          rsp_valid_o[r_idx] = 1'b1;
          rsp_data_o         = r_rsp_data;
          rsp_timeout_o      = r_rsp_to;
        end
        default: ;
      endcase
    end
  end

  // DRP address/data/we hold the last issued values between transactions.
  assign drp_we_o   = r_we;
  assign drp_addr_o = r_addr;
  assign drp_di_o   = r_di;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last     <= IDX_W'(N_REQ - 1);
      r_idx      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_di       <= '0;
      r_cnt      <= '0;
      r_rsp_data <= '0;
      r_rsp_to   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_idx  <= w_idx;
          r_we   <= req_we_i[w_idx];
          r_addr <= w_sel_addr;
          r_di   <= w_sel_data;
        end
        ISSUE: r_cnt <= '0;
        WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // Ready in the final cycle still counts as a normal completion.
          if (drp_rdy_i) begin
            r_rsp_data <= drp_do_i;
            r_rsp_to   <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_data <= '0;
            r_rsp_to   <= 1'b1;
          end
        end
        RESP: r_last <= r_idx;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xilinx_phy10g_drp_arbiter.sv
// Directed bench for the DRP arbiter: ordering, DRP pin values, latency, timeout, reset and lock.
module tb_xilinx_phy10g_drp_arbiter;

  logic         clk;
  logic         rst_i;
  logic [7:0]   req_valid_i;
  logic [7:0]   req_ready_o;
  logic [7:0]   req_we_i;
  logic [71:0]  req_addr_i;
  logic [127:0] req_data_i;
`ifdef DRP_ARB_LOCK_EN
  logic [7:0]   req_lock_i;
`endif
  logic [7:0]   rsp_valid_o;
  logic [15:0]  rsp_data_o;
  logic         rsp_timeout_o;
  logic         drp_en_o;
  logic         drp_we_o;
  logic [8:0]   drp_addr_o;
  logic [15:0]  drp_di_o;
  logic [15:0]  drp_do_i;
  logic         drp_rdy_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_delay = 0;
  logic [15:0] rdy_data = 16'h0000;

  int          acc_cyc_q[$];
  logic [7:0]  acc_vec_q[$];
  int          rsp_cyc_q[$];
  logic [7:0]  rsp_vec_q[$];
  logic [15:0] rsp_dat_q[$];
  logic        rsp_to_q[$];
  int          en_cyc_q[$];
  logic        en_we_q[$];
  logic [8:0]  en_addr_q[$];
  logic [15:0] en_di_q[$];

  xilinx_phy10g_drp_arbiter dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_we_i      (req_we_i),
    .req_addr_i    (req_addr_i),
    .req_data_i    (req_data_i),
`ifdef DRP_ARB_LOCK_EN
    .req_lock_i    (req_lock_i),
`endif
    .rsp_valid_o   (rsp_valid_o),
    .rsp_data_o    (rsp_data_o),
    .rsp_timeout_o (rsp_timeout_o),
    .drp_en_o      (drp_en_o),
    .drp_we_o      (drp_we_o),
    .drp_addr_o    (drp_addr_o),
    .drp_di_o      (drp_di_o),
    .drp_do_i      (drp_do_i),
    .drp_rdy_i     (drp_rdy_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Event recorder, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (req_ready_o != 8'h00) begin
      acc_cyc_q.push_back(cyc);
      acc_vec_q.push_back(req_ready_o);
    end
    if (rsp_valid_o != 8'h00) begin
      rsp_cyc_q.push_back(cyc);
      rsp_vec_q.push_back(rsp_valid_o);
      rsp_dat_q.push_back(rsp_data_o);
      rsp_to_q.push_back(rsp_timeout_o);
    end
    if (drp_en_o === 1'b1) begin
      en_cyc_q.push_back(cyc);
      en_we_q.push_back(drp_we_o);
      en_addr_q.push_back(drp_addr_o);
      en_di_q.push_back(drp_di_o);
    end
  end

  // DRP model: ready pulse rdy_delay cycles after enable; 0 means never.
  initial begin
    drp_rdy_i = 1'b0;
    drp_do_i  = 16'hBEEF;
    forever begin
      @(negedge clk);
      if (drp_en_o === 1'b1 && rdy_delay > 0) begin
        for (int i = 0; i < rdy_delay; i++) @(posedge clk);
        #1;
        drp_rdy_i = 1'b1;
        drp_do_i  = rdy_data;
        @(posedge clk);
        #1;
        drp_rdy_i = 1'b0;
        drp_do_i  = 16'hBEEF;
      end
    end
  end

  task automatic clear_log();
    acc_cyc_q.delete(); acc_vec_q.delete();
    rsp_cyc_q.delete(); rsp_vec_q.delete(); rsp_dat_q.delete(); rsp_to_q.delete();
    en_cyc_q.delete();  en_we_q.delete();   en_addr_q.delete(); en_di_q.delete();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_valid_i = 8'h00;
`ifdef DRP_ARB_LOCK_EN
    req_lock_i = 8'h00;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    clear_log();
  endtask

  // Advance until n responses are logged; each requester drops valid once accepted.
  task automatic run_until(input int n_rsp, input int budget);
    int seen;
    seen = acc_vec_q.size();
    for (int c = 0; c < budget && rsp_vec_q.size() < n_rsp; c++) begin
      @(posedge clk);
      #1;
      if (acc_vec_q.size() > seen) begin
        req_valid_i = req_valid_i & ~acc_vec_q[acc_vec_q.size()-1];
        seen = acc_vec_q.size();
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    req_valid_i = 8'h00;
    req_we_i = 8'h00;
    req_addr_i = '0;
    req_data_i = '0;
`ifdef DRP_ARB_LOCK_EN
    req_lock_i = 8'h00;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready_o, rsp_valid_o} !== 16'h0000) begin
      errors++; $display("FAIL reset_ready_rsp: got %h required 0000", {req_ready_o, rsp_valid_o});
    end
    checks++;
    if ({drp_en_o, drp_we_o, rsp_timeout_o} !== 3'b000) begin
      errors++; $display("FAIL reset_en_we_to: got %b required 000", {drp_en_o, drp_we_o, rsp_timeout_o});
    end
    checks++;
    if ({drp_addr_o, drp_di_o, rsp_data_o} !== 41'd0) begin
      errors++; $display("FAIL reset_buses: got %h required 0", {drp_addr_o, drp_di_o, rsp_data_o});
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_vec [3];
    exp_vec = '{8'h01, 8'h08, 8'h80};
    do_reset();
    rdy_delay = 3;
    rdy_data = 16'h0C0D;
    req_we_i = 8'h00;
    for (int i = 0; i < 8; i++) req_addr_i[i*9 +: 9] = 9'(9'h100 + i);
    req_valid_i = 8'h89;
    run_until(3, 80);
    checks++;
    if (acc_vec_q.size() != 3 || rsp_vec_q.size() != 3 || en_cyc_q.size() != 3) begin
      errors++;
      $display("FAIL rr_counts: got acc=%0d rsp=%0d en=%0d required 3/3/3",
               acc_vec_q.size(), rsp_vec_q.size(), en_cyc_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (acc_vec_q[i] !== exp_vec[i] || rsp_vec_q[i] !== exp_vec[i]) begin
          errors++;
          $display("FAIL rr_order%0d: got acc=%h rsp=%h required %h", i, acc_vec_q[i], rsp_vec_q[i], exp_vec[i]);
        end
        checks++;
        if (rsp_cyc_q[i] - acc_cyc_q[i] != 5) begin
          errors++; $display("FAIL rr_latency%0d: got %0d required 5", i, rsp_cyc_q[i] - acc_cyc_q[i]);
        end
        checks++;
        if (rsp_dat_q[i] !== 16'h0C0D || rsp_to_q[i] !== 1'b0) begin
          errors++; $display("FAIL rr_data%0d: got %h/%b required 0c0d/0", i, rsp_dat_q[i], rsp_to_q[i]);
        end
      end
      checks++;
      if (en_addr_q[1] !== 9'h103 || en_addr_q[2] !== 9'h107) begin
        errors++; $display("FAIL rr_addr: got %h,%h required 103,107", en_addr_q[1], en_addr_q[2]);
      end
      checks++;
      if (acc_cyc_q[1] - acc_cyc_q[0] != 6) begin
        errors++; $display("FAIL rr_spacing: got %0d required 6", acc_cyc_q[1] - acc_cyc_q[0]);
      end
    end
  endtask

  task automatic test_write();
    do_reset();
    rdy_delay = 2;
    rdy_data = 16'h7777;
    req_we_i = 8'h04;
    req_addr_i[2*9 +: 9] = 9'h05F;
    req_data_i[2*16 +: 16] = 16'hA5A5;
    req_valid_i = 8'h04;
    run_until(1, 30);
    checks++;
    if (acc_vec_q.size() != 1 || en_cyc_q.size() != 1 || rsp_vec_q.size() != 1) begin
      errors++;
      $display("FAIL wr_counts: got acc=%0d en=%0d rsp=%0d required 1/1/1",
               acc_vec_q.size(), en_cyc_q.size(), rsp_vec_q.size());
    end else begin
      checks++;
      if (en_cyc_q[0] - acc_cyc_q[0] != 1) begin
        errors++; $display("FAIL wr_en_time: got %0d required 1", en_cyc_q[0] - acc_cyc_q[0]);
      end
      checks++;
      if (en_we_q[0] !== 1'b1 || en_addr_q[0] !== 9'h05F || en_di_q[0] !== 16'hA5A5) begin
        errors++;
        $display("FAIL wr_drp_pins: got we=%b addr=%h di=%h required 1/05f/a5a5",
                 en_we_q[0], en_addr_q[0], en_di_q[0]);
      end
      checks++;
      if (rsp_vec_q[0] !== 8'h04 || rsp_to_q[0] !== 1'b0 || rsp_cyc_q[0] - acc_cyc_q[0] != 4) begin
        errors++;
        $display("FAIL wr_rsp: got vec=%h to=%b lat=%0d required 04/0/4",
                 rsp_vec_q[0], rsp_to_q[0], rsp_cyc_q[0] - acc_cyc_q[0]);
      end
    end
    @(negedge clk);
    checks++;
    if (drp_addr_o !== 9'h05F || drp_di_o !== 16'hA5A5 || drp_en_o !== 1'b0) begin
      errors++; $display("FAIL wr_hold: got addr=%h di=%h en=%b required 05f/a5a5/0", drp_addr_o, drp_di_o, drp_en_o);
    end
    req_we_i = 8'h00;
  endtask

  task automatic test_read();
    do_reset();
    rdy_delay = 1;
    rdy_data = 16'h1234;
    req_addr_i[4*9 +: 9] = 9'h011;
    req_valid_i = 8'h10;
    run_until(1, 30);
    checks++;
    if (rsp_vec_q.size() != 1 || en_cyc_q.size() != 1 || acc_cyc_q.size() != 1) begin
      errors++; $display("FAIL rd_counts: got rsp=%0d en=%0d required 1/1", rsp_vec_q.size(), en_cyc_q.size());
    end else begin
      checks++;
      if (en_we_q[0] !== 1'b0 || en_addr_q[0] !== 9'h011) begin
        errors++; $display("FAIL rd_drp_pins: got we=%b addr=%h required 0/011", en_we_q[0], en_addr_q[0]);
      end
      checks++;
      if (rsp_vec_q[0] !== 8'h10 || rsp_dat_q[0] !== 16'h1234 || rsp_cyc_q[0] - acc_cyc_q[0] != 3) begin
        errors++;
        $display("FAIL rd_rsp: got vec=%h data=%h lat=%0d required 10/1234/3",
                 rsp_vec_q[0], rsp_dat_q[0], rsp_cyc_q[0] - acc_cyc_q[0]);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    rdy_delay = 0;
    req_addr_i[1*9 +: 9] = 9'h0AA;
    req_valid_i = 8'h02;
    run_until(1, 300);
    checks++;
    if (rsp_vec_q.size() != 1 || en_cyc_q.size() != 1) begin
      errors++; $display("FAIL to_counts: got rsp=%0d en=%0d required 1/1", rsp_vec_q.size(), en_cyc_q.size());
    end else begin
      checks++;
      if (rsp_vec_q[0] !== 8'h02 || rsp_to_q[0] !== 1'b1 || rsp_dat_q[0] !== 16'h0000) begin
        errors++;
        $display("FAIL to_rsp: got vec=%h to=%b data=%h required 02/1/0000", rsp_vec_q[0], rsp_to_q[0], rsp_dat_q[0]);
      end
      checks++;
      if (rsp_cyc_q[0] - en_cyc_q[0] != 256) begin
        errors++; $display("FAIL to_latency: got %0d required 256", rsp_cyc_q[0] - en_cyc_q[0]);
      end
    end
  endtask

  task automatic test_rdy_at_limit();
    do_reset();
    rdy_delay = 255;
    rdy_data = 16'h5A5A;
    req_addr_i[3*9 +: 9] = 9'h033;
    req_valid_i = 8'h08;
    run_until(1, 300);
    checks++;
    if (rsp_vec_q.size() != 1 || en_cyc_q.size() != 1) begin
      errors++; $display("FAIL lim_counts: got rsp=%0d en=%0d required 1/1", rsp_vec_q.size(), en_cyc_q.size());
    end else begin
      checks++;
      if (rsp_to_q[0] !== 1'b0 || rsp_dat_q[0] !== 16'h5A5A || rsp_cyc_q[0] - en_cyc_q[0] != 256) begin
        errors++;
        $display("FAIL lim_rsp: got to=%b data=%h lat=%0d required 0/5a5a/256",
                 rsp_to_q[0], rsp_dat_q[0], rsp_cyc_q[0] - en_cyc_q[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int rel_cyc;
    do_reset();
    rdy_delay = 0;
    req_valid_i = 8'h01;
    for (int c = 0; c < 10 && acc_vec_q.size() < 1; c++) @(posedge clk);
    #1;
    req_valid_i = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(negedge clk);
    checks++;
    if (drp_en_o !== 1'b0 || rsp_valid_o !== 8'h00) begin
      errors++; $display("FAIL mid_rst_outputs: got en=%b rsp=%h required 0/00", drp_en_o, rsp_valid_o);
    end
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    req_valid_i = 8'h03;
    rel_cyc = cyc;
    for (int c = 0; c < 10 && acc_vec_q.size() < 2; c++) @(posedge clk);
    #1;
    req_valid_i = 8'h00;
    checks++;
    if (acc_vec_q.size() != 2) begin
      errors++; $display("FAIL mid_rst_accepts: got %0d required 2", acc_vec_q.size());
    end else begin
      checks++;
      if (acc_vec_q[1] !== 8'h01 || acc_cyc_q[1] != rel_cyc) begin
        errors++;
        $display("FAIL mid_rst_winner: got %h at +%0d required 01 at +0", acc_vec_q[1], acc_cyc_q[1] - rel_cyc);
      end
    end
    checks++;
    if (rsp_vec_q.size() != 0 || en_cyc_q.size() != 1) begin
      errors++; $display("FAIL mid_rst_abandon: got rsp=%0d en=%0d required 0/1", rsp_vec_q.size(), en_cyc_q.size());
    end
  endtask

`ifdef DRP_ARB_LOCK_EN
  task automatic test_lock();
    bit dropped;
    do_reset();
    rdy_delay = 1;
    dropped = 1'b0;
    req_lock_i = 8'h20;
    req_valid_i = 8'h60;
    for (int c = 0; c < 60 && rsp_vec_q.size() < 3; c++) begin
      @(posedge clk);
      #1;
      if (acc_vec_q.size() == 2 && !dropped) begin
        req_valid_i[5] = 1'b0;
        req_lock_i[5] = 1'b0;
        dropped = 1'b1;
      end
      if (acc_vec_q.size() == 3) req_valid_i[6] = 1'b0;
    end
    checks++;
    if (acc_vec_q.size() != 3) begin
      errors++; $display("FAIL lock_counts: got %0d required 3", acc_vec_q.size());
    end else begin
      checks++;
      if (acc_vec_q[0] !== 8'h20 || acc_vec_q[1] !== 8'h20 || acc_vec_q[2] !== 8'h40) begin
        errors++;
        $display("FAIL lock_order: got %h,%h,%h required 20,20,40", acc_vec_q[0], acc_vec_q[1], acc_vec_q[2]);
      end
      checks++;
      if (acc_cyc_q[1] - acc_cyc_q[0] != 4 || acc_cyc_q[2] - acc_cyc_q[1] != 5) begin
        errors++;
        $display("FAIL lock_timing: got %0d,%0d required 4,5",
                 acc_cyc_q[1] - acc_cyc_q[0], acc_cyc_q[2] - acc_cyc_q[1]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_write();
    test_read();
    test_timeout();
    test_rdy_at_limit();
    test_reset_mid();
`ifdef DRP_ARB_LOCK_EN
    test_lock();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
